// File: rtl/trax_pkg.sv
// Shared definitions for the Trax turn sequencer: move word layout, tile
// codes, timer widths and the sequencer state encoding.
package trax_pkg;

    // Move word layout: [21:20] tile, [19:10] col, [9:0] row
    localparam int MOVE_W   = 22;
    localparam int TILE_W   = 2;
    localparam int COORD_W  = 10;
    localparam int TILE_MSB = 21;
    localparam int TILE_LSB = 20;
    localparam int COL_MSB  = 19;
    localparam int COL_LSB  = 10;
    localparam int ROW_MSB  = 9;
    localparam int ROW_LSB  = 0;

    localparam logic [TILE_W-1:0] TILE_PLUS   = 2'b01;
    localparam logic [TILE_W-1:0] TILE_SLASH  = 2'b10;
    localparam logic [TILE_W-1:0] TILE_BSLASH = 2'b11;

    localparam int WDOG_W  = 16;
    localparam int ROUND_W = 16;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        APPLY_OPP  = 4'd1,
        AUTO_OPP   = 4'd2,
        COMMIT_OPP = 4'd3,
        CHOOSE     = 4'd4,
        APPLY_OWN  = 4'd5,
        AUTO_OWN   = 4'd6,
        COMMIT_OWN = 4'd7,
        SEND       = 4'd8,
        ERROR      = 4'd9
    } trax_state_t;

    // Phase states are the ones that hand work to an engine and wait for its done
    function automatic logic is_phase(input trax_state_t s);
        return (s == APPLY_OPP) || (s == AUTO_OPP) || (s == COMMIT_OPP) ||
               (s == CHOOSE)    || (s == APPLY_OWN) || (s == AUTO_OWN) ||
               (s == COMMIT_OWN);
    endfunction

endpackage

// File: rtl/trax_edge_sync.sv
// Brings the transceiver end_receive level into the clk domain and turns its
// rising edge into a single-cycle pulse.
module trax_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic edge_pulse
);
    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Two-flop synchroniser followed by the edge history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= d_in;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign edge_pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/trax_turn_sequencer.sv
// Turn sequencer for a Trax player: applies the opponent move, runs the
// forced-move and commit engines, asks the chooser for our move, applies it
// and hands it to the transmitter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a received move (end_receive rising edge)
// APPLY_OPP  | placing the opponent tile held in move_apply
// AUTO_OPP   | resolving forced tiles after the opponent move
// COMMIT_OPP | committing the board after the opponent move
// CHOOSE     | chooser searching for our move
// APPLY_OWN  | placing our tile held in move_apply
// AUTO_OWN   | resolving forced tiles after our move
// COMMIT_OWN | committing the board after our move
// SEND       | one cycle: start_transmit pulse, round advances
// ERROR      | no legal move or a phase timed out; left only by reset
module trax_turn_sequencer #(
    parameter int MOVE_W  = trax_pkg::MOVE_W,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              end_receive,
    input  logic              color,
    input  logic [MOVE_W-1:0] move_rx,
    output logic              apply_start,
    output logic              auto_start,
    output logic              commit_start,
    output logic              choose_start,
    input  logic              apply_done,
    input  logic              auto_done,
    input  logic              commit_done,
    input  logic              choose_done,
    input  logic [MOVE_W-1:0] chosen_move,
    input  logic              chosen_valid,
    output logic [MOVE_W-1:0] move_apply,
    output logic [MOVE_W-1:0] move_tx,
    output logic              start_transmit,
    output logic              busy,
    output logic              error,
    output logic              overrun,
    output logic [15:0]       round
);
    import trax_pkg::*;

    // Watchdog counts down from TIMEOUT-1; the phase has used its budget when it reaches zero
    localparam logic [WDOG_W-1:0] WD_LOAD = WDOG_W'(TIMEOUT - 1);

    trax_state_t         state_q;
    trax_state_t         state_d;
    logic                edge_pulse;
    logic                entering;
    logic                wdog_expired;
    logic [WDOG_W-1:0]   wdog_q;
    logic [ROUND_W-1:0]  round_q;
    logic [MOVE_W-1:0]   move_apply_q;
    logic [MOVE_W-1:0]   move_apply_d;
    logic [MOVE_W-1:0]   move_tx_q;
    logic [MOVE_W-1:0]   move_tx_d;
    logic [MOVE_W-1:0]   first_move;
    logic                apply_start_q;
    logic                apply_start_d;
    logic                auto_start_q;
    logic                auto_start_d;
    logic                commit_start_q;
    logic                commit_start_d;
    logic                choose_start_q;
    logic                choose_start_d;
    logic                start_transmit_q;
    logic                start_transmit_d;
    logic                overrun_q;
    logic                busy_int;

    trax_edge_sync u_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .d_in       (end_receive),
        .edge_pulse (edge_pulse)
    );

    // White opening move: a plus tile at the origin
    always_comb begin
        first_move = '0;
        first_move[MOVE_W-1 -: TILE_W] = TILE_PLUS;
    end

    assign busy_int     = (state_q != IDLE) && (state_q != ERROR);
    assign wdog_expired = is_phase(state_q) && (wdog_q == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, move latching and start-pulse decode; a done always beats the watchdog
    always_comb begin
        state_d      = state_q;
        move_apply_d = move_apply_q;
        move_tx_d    = move_tx_q;

        unique case (state_q)
            IDLE: begin
                if (edge_pulse) begin
                    if ((round_q == '0) && !color) begin
                        move_apply_d = first_move;
                        move_tx_d    = first_move;
                        state_d      = APPLY_OWN;
                    end else begin
                        move_apply_d = move_rx;
                        state_d      = APPLY_OPP;
                    end
                end
            end
            APPLY_OPP: begin
                if (apply_done)        state_d = AUTO_OPP;
                else if (wdog_expired) state_d = ERROR;
            end
            AUTO_OPP: begin
                if (auto_done)         state_d = COMMIT_OPP;
                else if (wdog_expired) state_d = ERROR;
            end
            COMMIT_OPP: begin
                if (commit_done)       state_d = CHOOSE;
                else if (wdog_expired) state_d = ERROR;
            end
            CHOOSE: begin
                if (choose_done) begin
                    if (chosen_valid) begin
                        move_apply_d = chosen_move;
                        move_tx_d    = chosen_move;
                        state_d      = APPLY_OWN;
                    end else begin
                        state_d = ERROR;
                    end
                end else if (wdog_expired) begin
                    state_d = ERROR;
                end
            end
            APPLY_OWN: begin
                if (apply_done)        state_d = AUTO_OWN;
                else if (wdog_expired) state_d = ERROR;
            end
            AUTO_OWN: begin
                if (auto_done)         state_d = COMMIT_OWN;
                else if (wdog_expired) state_d = ERROR;
            end
            COMMIT_OWN: begin
                if (commit_done)       state_d = SEND;
                else if (wdog_expired) state_d = ERROR;
            end
            SEND:    state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase

        entering         = (state_d != state_q);
        apply_start_d    = entering && ((state_d == APPLY_OPP) || (state_d == APPLY_OWN));
        auto_start_d     = entering && ((state_d == AUTO_OPP) || (state_d == AUTO_OWN));
        commit_start_d   = entering && ((state_d == COMMIT_OPP) || (state_d == COMMIT_OWN));
        choose_start_d   = entering && (state_d == CHOOSE);
        start_transmit_d = entering && (state_d == SEND);
    end

    // Move registers, start pulses, watchdog, turn counter and overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_apply_q     <= '0;
            move_tx_q        <= '0;
            apply_start_q    <= 1'b0;
            auto_start_q     <= 1'b0;
            commit_start_q   <= 1'b0;
            choose_start_q   <= 1'b0;
            start_transmit_q <= 1'b0;
            wdog_q           <= '0;
            round_q          <= '0;
            overrun_q        <= 1'b0;
        end else begin
            move_apply_q     <= move_apply_d;
            move_tx_q        <= move_tx_d;
            apply_start_q    <= apply_start_d;
            auto_start_q     <= auto_start_d;
            commit_start_q   <= commit_start_d;
            choose_start_q   <= choose_start_d;
            start_transmit_q <= start_transmit_d;

            if (entering) begin
                wdog_q <= WD_LOAD;
            end else if (wdog_q != '0) begin
                wdog_q <= wdog_q - 16'd1;
            end

            if (state_q == SEND) begin
                round_q <= round_q + 16'd1;
            end

            // A move arriving mid-turn is dropped; only the flag remembers it
            if (edge_pulse && busy_int) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign apply_start    = apply_start_q;
    assign auto_start     = auto_start_q;
    assign commit_start   = commit_start_q;
    assign choose_start   = choose_start_q;
    assign start_transmit = start_transmit_q;
    assign move_apply     = move_apply_q;
    assign move_tx        = move_tx_q;
    assign busy           = busy_int;
    assign error          = (state_q == ERROR);
    assign overrun        = overrun_q;
    assign round          = round_q;

endmodule

// File: tb/tb_trax_turn_sequencer.sv
// Self-checking bench for trax_turn_sequencer: a constant vector table, hand
// sequences for the multi-cycle corners, and randomized turns against a
// turn-level reference model.
module tb_trax_turn_sequencer;

    localparam int MW = 22;
    localparam int TO = 16;
    localparam logic [MW-1:0] FIRST_MOVE = 22'h100000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          end_receive = 1'b0;
    logic          color = 1'b0;
    logic [MW-1:0] move_rx = '0;
    logic          apply_start, auto_start, commit_start, choose_start;
    logic          apply_done = 1'b0, auto_done = 1'b0, commit_done = 1'b0, choose_done = 1'b0;
    logic [MW-1:0] chosen_move = '0;
    logic          chosen_valid = 1'b0;
    logic [MW-1:0] move_apply, move_tx;
    logic          start_transmit, busy, error, overrun;
    logic [15:0]   round;

    int            checks = 0;
    int            failures = 0;
    string         seq = "";
    int            resp_delay = 2;
    logic          hold_auto = 1'b0;
    int            auto_kick_req = 0;
    logic [MW-1:0] cfg_chosen = '0;
    logic          cfg_valid = 1'b1;

    int unsigned   m_round;
    logic [MW-1:0] m_tx;

    typedef struct {
        logic          rst_before;
        logic          c;
        logic [MW-1:0] mrx;
        logic [MW-1:0] ch;
        logic          v;
        logic [1:0]    kind;
        logic [MW-1:0] eapply;
        logic [MW-1:0] etx;
        logic [15:0]   eround;
        logic          eerr;
    } vec_t;

    vec_t vt [5];

    trax_turn_sequencer #(.MOVE_W(MW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .end_receive    (end_receive),
        .color          (color),
        .move_rx        (move_rx),
        .apply_start    (apply_start),
        .auto_start     (auto_start),
        .commit_start   (commit_start),
        .choose_start   (choose_start),
        .apply_done     (apply_done),
        .auto_done      (auto_done),
        .commit_done    (commit_done),
        .choose_done    (choose_done),
        .chosen_move    (chosen_move),
        .chosen_valid   (chosen_valid),
        .move_apply     (move_apply),
        .move_tx        (move_tx),
        .start_transmit (start_transmit),
        .busy           (busy),
        .error          (error),
        .overrun        (overrun),
        .round          (round)
    );

    always #5 clk = ~clk;

    // Engine emulator and pulse logger: records every start pulse as a letter
    // and answers each start with its done after resp_delay cycles.
    initial begin : responder
        int cnt [4];
        int kick_seen;
        kick_seen = 0;
        for (int i = 0; i < 4; i++) cnt[i] = -1;
        forever begin
            @(negedge clk);
            apply_done   = 1'b0;
            auto_done    = 1'b0;
            commit_done  = 1'b0;
            choose_done  = 1'b0;
            chosen_valid = 1'b0;
            chosen_move  = '0;
            if (reset) begin
                for (int i = 0; i < 4; i++) cnt[i] = -1;
            end else begin
                if (apply_start)    seq = {seq, "A"};
                if (auto_start)     seq = {seq, "U"};
                if (commit_start)   seq = {seq, "C"};
                if (choose_start)   seq = {seq, "H"};
                if (start_transmit) seq = {seq, "T"};
                for (int i = 0; i < 4; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            cnt[i] = -1;
                            case (i)
                                0: apply_done = 1'b1;
                                1: auto_done = 1'b1;
                                2: commit_done = 1'b1;
                                default: begin
                                    choose_done  = 1'b1;
                                    chosen_move  = cfg_chosen;
                                    chosen_valid = cfg_valid;
                                end
                            endcase
                        end
                    end
                end
                if (apply_start) cnt[0] = resp_delay;
                if (auto_start && !hold_auto) cnt[1] = resp_delay;
                if (commit_start) cnt[2] = resp_delay;
                if (choose_start) cnt[3] = resp_delay;
                if (auto_kick_req != kick_seen) begin
                    kick_seen = auto_kick_req;
                    auto_done = 1'b1;
                end
            end
        end
    end

    // Global time limit so the run can never hang
    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkm(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chks(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic string since(input int mark);
        if (seq.len() <= mark) return "";
        return seq.substr(mark, seq.len() - 1);
    endfunction

    // Start-pulse order for each kind of turn: first white move, full turn, no legal move
    function automatic string kind_seq(input logic [1:0] k);
        case (k)
            2'd0:    return "AUCT";
            2'd1:    return "AUCHAUCT";
            default: return "AUCH";
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (busy === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk1(name, ok, 1'b1);
    endtask

    task automatic start_edge(input logic c, input logic [MW-1:0] mrx);
        color       = c;
        move_rx     = mrx;
        end_receive = 1'b1;
        tick();
        tick();
        end_receive = 1'b0;
    endtask

    task automatic run_turn(input logic c, input logic [MW-1:0] mrx, input logic [MW-1:0] ch,
                            input logic v, output string got);
        int mark;
        mark       = seq.len();
        cfg_chosen = ch;
        cfg_valid  = v;
        start_edge(c, mrx);
        wait_busy(1'b1, 10, "turn_busy_rise");
        wait_busy(1'b0, 400, "turn_busy_fall");
        got = since(mark);
    endtask

    // Turn-level reference: what one received move should do to the player
    task automatic model_turn(input logic c, input logic [MW-1:0] mrx, input logic [MW-1:0] ch,
                              input logic v, output logic [1:0] kind,
                              output logic [MW-1:0] eapply, output logic eerr);
        if (m_round == 0 && c == 1'b0) begin
            kind    = 2'd0;
            eapply  = FIRST_MOVE;
            m_tx    = FIRST_MOVE;
            m_round = (m_round + 1) % 65536;
            eerr    = 1'b0;
        end else if (v) begin
            kind    = 2'd1;
            eapply  = ch;
            m_tx    = ch;
            m_round = (m_round + 1) % 65536;
            eerr    = 1'b0;
        end else begin
            kind    = 2'd2;
            eapply  = mrx;
            eerr    = 1'b1;
        end
    endtask

    initial begin : main
        string         got;
        int            mark;
        logic          ok;
        logic          rc, rv, eerr;
        logic [MW-1:0] rmrx, rch, eapply;
        logic [1:0]    kind;

        vt[0] = '{1'b1, 1'b0, 22'h2AAAAA, 22'h000000, 1'b1, 2'd0, 22'h100000, 22'h100000, 16'd1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 22'h0C0123, 22'h300C05, 1'b1, 2'd1, 22'h300C05, 22'h300C05, 16'd2, 1'b0};
        vt[2] = '{1'b1, 1'b1, 22'h200401, 22'h10280A, 1'b1, 2'd1, 22'h10280A, 22'h10280A, 16'd1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 22'h3FFFFF, 22'h000001, 1'b1, 2'd1, 22'h000001, 22'h000001, 16'd2, 1'b0};
        vt[4] = '{1'b0, 1'b1, 22'h155555, 22'h2FFFFF, 1'b0, 2'd2, 22'h155555, 22'h000001, 16'd2, 1'b1};

        // Reset state
        tick();
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk16("rst_round", round, 16'd0);
        chkm("rst_move_apply", move_apply, '0);
        chkm("rst_move_tx", move_tx, '0);
        reset = 1'b0;
        tick();

        // Constant vector table
        for (int i = 0; i < 5; i++) begin
            if (vt[i].rst_before) do_reset();
            resp_delay = 2;
            run_turn(vt[i].c, vt[i].mrx, vt[i].ch, vt[i].v, got);
            chks("vec_seq", got, kind_seq(vt[i].kind));
            chkm("vec_move_apply", move_apply, vt[i].eapply);
            chkm("vec_move_tx", move_tx, vt[i].etx);
            chk16("vec_round", round, vt[i].eround);
            chk1("vec_error", error, vt[i].eerr);
            chk1("vec_overrun", overrun, 1'b0);
        end

        // Withheld auto_done: error exactly 16 cycles after auto_start, later dones ignored
        do_reset();
        hold_auto  = 1'b1;
        resp_delay = 2;
        cfg_valid  = 1'b1;
        mark       = seq.len();
        start_edge(1'b1, 22'h200401);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (auto_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk1("to_auto_start_seen", ok, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        chk1("to_no_error_at_15", error, 1'b0);
        tick();
        chk1("to_error_at_16", error, 1'b1);
        chk1("to_busy_low", busy, 1'b0);
        auto_kick_req++;
        for (int i = 0; i < 6; i++) tick();
        chk1("to_error_sticky", error, 1'b1);
        chks("to_seq", since(mark), "AU");
        hold_auto = 1'b0;

        // Second received move while the chooser is busy
        do_reset();
        resp_delay = 8;
        cfg_chosen = 22'h2C0C0C;
        cfg_valid  = 1'b1;
        mark       = seq.len();
        start_edge(1'b1, 22'h200401);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (choose_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk1("ov_choose_start_seen", ok, 1'b1);
        start_edge(1'b0, 22'h0ABCDE);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (overrun) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk1("ov_flag_set", ok, 1'b1);
        chk1("ov_still_busy", busy, 1'b1);
        chkm("ov_move_apply_kept", move_apply, 22'h200401);
        wait_busy(1'b0, 200, "ov_busy_fall");
        for (int i = 0; i < 10; i++) tick();
        chks("ov_seq", since(mark), "AUCHAUCT");
        chkm("ov_move_tx", move_tx, 22'h2C0C0C);
        chk16("ov_round", round, 16'd1);
        chk1("ov_sticky", overrun, 1'b1);
        chk1("ov_no_new_turn", busy, 1'b0);

        // Reset in the middle of COMMIT_OPP
        do_reset();
        resp_delay = 2;
        start_edge(1'b1, 22'h1003FF);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (commit_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk1("mr_commit_start_seen", ok, 1'b1);
        tick();
        chk1("mr_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_starts", |{apply_start, auto_start, commit_start, choose_start, start_transmit}, 1'b0);
        chkm("mr_move_apply", move_apply, '0);
        chkm("mr_move_tx", move_tx, '0);
        chk16("mr_round", round, 16'd0);
        chk1("mr_error", error, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        mark  = seq.len();
        for (int i = 0; i < 12; i++) tick();
        chks("mr_no_pulse_after", since(mark), "");
        chk1("mr_idle_after", busy, 1'b0);

        // Randomized turns against the reference model
        do_reset();
        m_round = 0;
        m_tx    = '0;
        for (int n = 0; n < 24; n++) begin
            rc         = 1'($urandom_range(0, 1));
            rmrx       = MW'($urandom);
            rch        = MW'($urandom);
            rv         = ($urandom_range(0, 7) != 0);
            resp_delay = $urandom_range(1, 5);
            model_turn(rc, rmrx, rch, rv, kind, eapply, eerr);
            run_turn(rc, rmrx, rch, rv, got);
            chks("rnd_seq", got, kind_seq(kind));
            chkm("rnd_move_apply", move_apply, eapply);
            chkm("rnd_move_tx", move_tx, m_tx);
            chk16("rnd_round", round, 16'(m_round));
            chk1("rnd_error", error, eerr);
            chk1("rnd_overrun", overrun, 1'b0);
            if (eerr) begin
                do_reset();
                m_round = 0;
                m_tx    = '0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
